prefetch_unit: RTL and testbench
================================

PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 Parameter XLEN, default 32, data/address width.
REQ-002 Parameter DEPTH, default 4, instruction buffer entries; power of two, >=2.
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rstn  in  1  asynchronous active-low reset.
REQ-006 i_redirect_valid  in  1  flush and restart fetch (branch/jump/trap).
REQ-007 i_redirect_addr  in  XLEN  restart address.
REQ-008 o_if_valid / i_if_ready  out/in  1  instruction handshake to decode.
REQ-009 o_if_instr  out  XLEN  instruction word.
REQ-010 o_if_pc  out  XLEN  address of o_if_instr.
REQ-011 o_if_fault  out  1  bus error on this entry.
REQ-012 o_im_arvalid / i_im_arready  out/in  1  instruction-memory read-address handshake.
REQ-013 o_im_araddr  out  XLEN  read address.
REQ-014 i_im_rvalid / o_im_rready  in/out  1  read-data handshake.
REQ-015 i_im_rdata  in  XLEN  read data.
REQ-016 i_im_rresp  in  2  response code; nonzero = error.

Function
REQ-017 fetch_pc register; increments by 4 on every AR handshake (arvalid & arready); wraps modulo 2^XLEN.
REQ-018 o_im_araddr = fetch_pc; bits [1:0] always 0.
REQ-019 Credit rule: o_im_arvalid asserted only when outstanding + fifo_count < DEPTH.
REQ-020 Once o_im_arvalid is high, it and o_im_araddr hold stable until handshake, including across a redirect.
REQ-021 o_im_rready is constantly 1 out of reset; the credit rule guarantees space.
REQ-022 outstanding counter: +1 per AR handshake, -1 per R handshake, both same cycle = unchanged; range 0..DEPTH.
REQ-023 rsp_pc register tags accepted responses; +4 per non-discarded R handshake.
REQ-024 Non-discarded R handshake writes {rdata, rsp_pc, rresp!=0} into FIFO; entry visible on o_if_valid the next cycle.
REQ-025 FIFO pops on o_if_valid & i_if_ready; simultaneous push and pop when full or empty are legal and keep count consistent.
REQ-026 Redirect cycle: FIFO emptied (o_if_valid low next cycle); fetch_pc and rsp_pc := {i_redirect_addr[XLEN-1:2], 2'b00}; discard counter := outstanding (+1 if AR handshake this cycle, -1 if R handshake this cycle).
REQ-027 R handshakes while discard counter > 0 decrement it and are not written to FIFO.
REQ-028 Pending un-handshaken AR at redirect completes at its old address and is counted as discard; new-address AR issues the cycle after that handshake.
REQ-029 No pending AR at redirect: first new-address AR asserted the cycle after redirect.
REQ-030 Redirect coincident with R handshake or pop: redirect wins; data dropped, pop ignored.
REQ-031 Error response: entry delivered with o_if_fault=1; fetching continues.

Reset
REQ-032 Under rstn low: o_if_valid=0, o_im_arvalid=0, o_im_rready=0, o_if_fault=0, o_if_instr=0, o_if_pc=0, o_im_araddr=RESET_PC, all counters 0, fetch_pc=rsp_pc=RESET_PC.
REQ-033 First AR (address RESET_PC) asserted in the first cycle after rstn deasserts.
REQ-034 Reset mid-operation discards all buffered and outstanding state; late responses after reset are ignored only by the memory's own reset.

Structure
REQ-035 Response codes (RespOkay=0, RespSlvErr=2, RespDecErr=3) declared in riscv_pkg.
REQ-036 Buffer is sub-module fetch_fifo, parametrised by width and DEPTH.

Verification
REQ-037 Reset release, arready=1, 1-cycle memory -> AR addresses 0,4,8,12; decode sees PC 0,4,8,12 in order.
REQ-038 i_if_ready=0, DEPTH=4 -> exactly 4 ARs issue, then arvalid stays 0; one pop -> exactly one further AR.
REQ-039 2 outstanding, redirect to 0x103 -> next 2 responses dropped; first delivered o_if_pc=0x100.
REQ-040 arvalid high, arready low, redirect to 0x200 -> old address held to handshake, then AR 0x200.
REQ-041 rresp=2 on PC 0x8 -> entry 0x8 with o_if_fault=1; PC 0xC follows normally.
REQ-042 Redirect in same cycle as R handshake and pop -> no stale entry delivered; outstanding counter returns to 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch path: bus response codes
// and the small helpers that interpret them.
package riscv_pkg;

    // Read-response codes returned by the instruction memory.
    typedef enum logic [1:0] {
        RespOkay   = 2'd0,
        RespExOkay = 2'd1,
        RespSlvErr = 2'd2,
        RespDecErr = 2'd3
    } resp_e;

    // Every instruction word occupies four bytes.
    localparam int unsigned InstrBytes = 4;

    // Any response other than OKAY marks the fetched word as faulting.
    function automatic logic resp_is_error(input logic [1:0] resp);
        return resp != RespOkay;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between the memory response channel and decode.
// Flat payload, power-of-two depth, flush overrides push and pop.
module fetch_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    import riscv_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty, full, do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty;
    // A full buffer still accepts a word when the head leaves in the same cycle.
    assign do_push = push_i & (~full | do_pop);

    // Pointer and occupancy next-state; a flush discards everything.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + AW'(1);
            if (do_pop)  rptr_d = rptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Payload storage; contents are only meaningful behind a valid count.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
    end

    assign valid_o = ~empty;
    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetcher: issues sequential reads under a credit limit,
// buffers responses tagged with their PC and handles redirects by
// discarding every read still in flight at the moment of the redirect.
module prefetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_addr,
    output logic            o_if_valid,
    input  logic            i_if_ready,
    output logic [XLEN-1:0] o_if_instr,
    output logic [XLEN-1:0] o_if_pc,
    output logic            o_if_fault,
    output logic            o_im_arvalid,
    input  logic            i_im_arready,
    output logic [XLEN-1:0] o_im_araddr,
    input  logic            i_im_rvalid,
    output logic            o_im_rready,
    input  logic [XLEN-1:0] i_im_rdata,
    input  logic [1:0]      i_im_rresp
);
    import riscv_pkg::*;

    localparam int              CW         = $clog2(DEPTH+1);
    localparam int              FW         = 2*XLEN + 1;
    localparam logic [XLEN-1:0] RESET_PC_A = {RESET_PC[XLEN-1:2], 2'b00};
    localparam logic [XLEN-1:0] STEP       = XLEN'(InstrBytes);

    logic            run_q;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [XLEN-1:0] pend_addr_q, pend_addr_d;
    logic            pend_q, pend_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;

    logic            ar_hs, r_hs, ar_stall, discarding, push, pop, credit_ok;
    logic [XLEN-1:0] redir_addr;
    logic            fifo_valid;
    logic [FW-1:0]   fifo_rdata;
    logic [CW-1:0]   fifo_count;

    assign redir_addr = i_redirect_addr & ~XLEN'(3);
    assign ar_hs      = o_im_arvalid & i_im_arready;
    assign r_hs       = i_im_rvalid & o_im_rready;
    assign ar_stall   = o_im_arvalid & ~i_im_arready;
    assign discarding = (discard_q != '0);
    // Redirect wins over a coincident response or pop.
    assign push       = r_hs & ~i_redirect_valid & ~discarding;
    assign pop        = fifo_valid & i_if_ready & ~i_redirect_valid;

    // Every read in flight or buffered holds a slot, so responses never stall.
    // Credit only grows between handshakes, which keeps a raised arvalid stable.
    assign credit_ok    = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CW+1)'(DEPTH);
    assign o_im_arvalid = run_q & credit_ok;
    assign o_im_araddr  = fetch_pc_q;
    assign o_im_rready  = run_q;

    // Fetch address: a redirect during a stalled read is parked until that read completes.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        if (i_redirect_valid) begin
            if (ar_stall) begin
                pend_d      = 1'b1;
                pend_addr_d = redir_addr;
            end else begin
                fetch_pc_d = redir_addr;
                pend_d     = 1'b0;
            end
        end else if (ar_hs) begin
            if (pend_q) begin
                fetch_pc_d = pend_addr_q;
                pend_d     = 1'b0;
            end else begin
                fetch_pc_d = fetch_pc_q + STEP;
            end
        end
    end

    // In-flight and discard accounting; a parked read adds its own discard when it completes.
    always_comb begin
        outstanding_d = outstanding_q + CW'(ar_hs) - CW'(r_hs);
        if (i_redirect_valid) begin
            discard_d = outstanding_d;
        end else begin
            discard_d = discard_q - CW'(r_hs & discarding) + CW'(ar_hs & pend_q);
        end
    end

    // PC tag for the next accepted response.
    always_comb begin
        rsp_pc_d = rsp_pc_q;
        if (i_redirect_valid) rsp_pc_d = redir_addr;
        else if (push)        rsp_pc_d = rsp_pc_q + STEP;
    end

    // Control state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_q         <= 1'b0;
            fetch_pc_q    <= RESET_PC_A;
            rsp_pc_q      <= RESET_PC_A;
            pend_q        <= 1'b0;
            pend_addr_q   <= RESET_PC_A;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            run_q         <= 1'b1;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            pend_q        <= pend_d;
            pend_addr_q   <= pend_addr_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .flush_i (i_redirect_valid),
        .push_i  (push),
        .wdata_i ({i_im_rdata, rsp_pc_q, resp_is_error(i_im_rresp)}),
        .pop_i   (pop),
        .valid_o (fifo_valid),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count)
    );

    // Decode sees zeros whenever no entry is presented.
    assign o_if_valid = fifo_valid;
    assign o_if_instr = fifo_valid ? fifo_rdata[FW-1:XLEN+1] : '0;
    assign o_if_pc    = fifo_valid ? fifo_rdata[XLEN:1]      : '0;
    assign o_if_fault = fifo_valid & fifo_rdata[0];

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit with a one-cycle instruction memory.
module tb_prefetch_unit;

    localparam logic [31:0] MAGIC = 32'hC0DE_0000;

    logic        clk;
    logic        rstn;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_addr;
    logic        o_if_valid;
    logic        i_if_ready;
    logic [31:0] o_if_instr;
    logic [31:0] o_if_pc;
    logic        o_if_fault;
    logic        o_im_arvalid;
    logic        i_im_arready;
    logic [31:0] o_im_araddr;
    logic        i_im_rvalid;
    logic        o_im_rready;
    logic [31:0] i_im_rdata;
    logic [1:0]  i_im_rresp;

    int vectors;
    int miscompares;

    int          budget;
    logic        err_en;
    logic [31:0] err_addr;
    logic [31:0] mq[$];
    logic [31:0] ar_log[$];
    logic [31:0] dl_pc[$];
    logic [31:0] dl_instr[$];
    logic [31:0] dl_fault[$];
    logic        m_ar, m_r;
    logic [31:0] m_addr;

    prefetch_unit #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_addr  (i_redirect_addr),
        .o_if_valid       (o_if_valid),
        .i_if_ready       (i_if_ready),
        .o_if_instr       (o_if_instr),
        .o_if_pc          (o_if_pc),
        .o_if_fault       (o_if_fault),
        .o_im_arvalid     (o_im_arvalid),
        .i_im_arready     (i_im_arready),
        .o_im_araddr      (o_im_araddr),
        .i_im_rvalid      (i_im_rvalid),
        .o_im_rready      (o_im_rready),
        .i_im_rdata       (i_im_rdata),
        .i_im_rresp       (i_im_rresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder and handshake monitor: sample mid-cycle, update after the edge.
    initial begin
        i_im_rvalid = 1'b0;
        i_im_rdata  = '0;
        i_im_rresp  = 2'd0;
        forever begin
            @(negedge clk);
            m_ar   = o_im_arvalid && i_im_arready;
            m_addr = o_im_araddr;
            m_r    = i_im_rvalid && o_im_rready;
            if (m_ar) ar_log.push_back(m_addr);
            if (o_if_valid && i_if_ready && !i_redirect_valid) begin
                dl_pc.push_back(o_if_pc);
                dl_instr.push_back(o_if_instr);
                dl_fault.push_back({31'd0, o_if_fault});
            end
            @(posedge clk);
            #2;
            if (!rstn) begin
                mq.delete();
            end else begin
                if (m_r) begin
                    void'(mq.pop_front());
                    budget = budget - 1;
                end
                if (m_ar) mq.push_back(m_addr);
            end
            if (mq.size() > 0 && budget > 0) begin
                i_im_rvalid = 1'b1;
                i_im_rdata  = mq[0] ^ MAGIC;
                i_im_rresp  = (err_en && mq[0] == err_addr) ? 2'd2 : 2'd0;
            end else begin
                i_im_rvalid = 1'b0;
                i_im_rdata  = '0;
                i_im_rresp  = 2'd0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic arready, input logic ifready, input int bud);
        rstn             = 1'b0;
        i_redirect_valid = 1'b0;
        i_redirect_addr  = '0;
        i_im_arready     = arready;
        i_if_ready       = ifready;
        budget           = bud;
        err_en           = 1'b0;
        err_addr         = '0;
        repeat (2) @(posedge clk);
        #1;
        ar_log.delete();
        dl_pc.delete();
        dl_instr.delete();
        dl_fault.delete();
        rstn = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Reset state, sampled while rstn is low.
        rstn             = 1'b0;
        i_redirect_valid = 1'b0;
        i_redirect_addr  = '0;
        i_im_arready     = 1'b1;
        i_if_ready       = 1'b1;
        budget           = 1000;
        err_en           = 1'b0;
        err_addr         = '0;
        repeat (2) @(posedge clk);
        at_neg();
        check("rst_arvalid", {31'd0, o_im_arvalid}, 32'd0);
        check("rst_rready",  {31'd0, o_im_rready},  32'd0);
        check("rst_ifvalid", {31'd0, o_if_valid},   32'd0);
        check("rst_fault",   {31'd0, o_if_fault},   32'd0);
        check("rst_instr",   o_if_instr,            32'h0);
        check("rst_pc",      o_if_pc,               32'h0);
        check("rst_araddr",  o_im_araddr,           32'h0);

        // Streaming fetch after reset.
        do_reset(1'b1, 1'b1, 1000);
        tick(1);
        at_neg();
        check("t1_first_arvalid", {31'd0, o_im_arvalid}, 32'd1);
        check("t1_first_araddr",  o_im_araddr,           32'h0);
        check("t1_rready",        {31'd0, o_im_rready},  32'd1);
        tick(10);
        check("t1_ar0", ar_log[0], 32'h0);
        check("t1_ar1", ar_log[1], 32'h4);
        check("t1_ar2", ar_log[2], 32'h8);
        check("t1_ar3", ar_log[3], 32'hC);
        check("t1_pc0", dl_pc[0], 32'h0);
        check("t1_pc1", dl_pc[1], 32'h4);
        check("t1_pc2", dl_pc[2], 32'h8);
        check("t1_pc3", dl_pc[3], 32'hC);
        check("t1_instr0", dl_instr[0], 32'hC0DE_0000);
        check("t1_instr3", dl_instr[3], 32'hC0DE_000C);

        // Decode stalled: credit stops fetch at the buffer depth.
        do_reset(1'b1, 1'b0, 1000);
        tick(10);
        at_neg();
        check("t2_ar_count",  32'(ar_log.size()),      32'd4);
        check("t2_arvalid",   {31'd0, o_im_arvalid},   32'd0);
        check("t2_ifvalid",   {31'd0, o_if_valid},     32'd1);
        check("t2_head_pc",   o_if_pc,                 32'h0);
        tick(1);
        i_if_ready = 1'b1;
        tick(1);
        i_if_ready = 1'b0;
        tick(6);
        check("t2_ar_count2", 32'(ar_log.size()),      32'd5);
        check("t2_ar4",       ar_log[4],               32'h10);
        check("t2_pop_count", 32'(dl_pc.size()),       32'd1);
        check("t2_head_pc2",  o_if_pc,                 32'h4);

        // Redirect with two reads outstanding and no pending address.
        do_reset(1'b1, 1'b0, 2);
        tick(10);
        check("t3_ar_count", 32'(ar_log.size()), 32'd4);
        i_redirect_valid = 1'b1;
        i_redirect_addr  = 32'h103;
        at_neg();
        check("t3_arvalid_at_redir", {31'd0, o_im_arvalid}, 32'd0);
        tick(1);
        i_redirect_valid = 1'b0;
        budget           = 1000;
        i_if_ready       = 1'b1;
        at_neg();
        check("t3_flushed",   {31'd0, o_if_valid},   32'd0);
        check("t3_arvalid",   {31'd0, o_im_arvalid}, 32'd1);
        check("t3_araddr",    o_im_araddr,           32'h100);
        tick(12);
        check("t3_ar4",       ar_log[4],   32'h100);
        check("t3_pc0",       dl_pc[0],    32'h100);
        check("t3_instr0",    dl_instr[0], 32'hC0DE_0100);
        check("t3_pc1",       dl_pc[1],    32'h104);

        // Redirect while a read address is stalled.
        do_reset(1'b0, 1'b1, 1000);
        tick(2);
        i_redirect_valid = 1'b1;
        i_redirect_addr  = 32'h200;
        at_neg();
        check("t4_arvalid_at_redir", {31'd0, o_im_arvalid}, 32'd1);
        tick(1);
        i_redirect_valid = 1'b0;
        at_neg();
        check("t4_hold_valid", {31'd0, o_im_arvalid}, 32'd1);
        check("t4_hold_addr",  o_im_araddr,           32'h0);
        tick(1);
        i_im_arready = 1'b1;
        at_neg();
        check("t4_hs_addr",    o_im_araddr,           32'h0);
        tick(1);
        at_neg();
        check("t4_new_addr",   o_im_araddr,           32'h200);
        tick(10);
        check("t4_ar0",  ar_log[0], 32'h0);
        check("t4_ar1",  ar_log[1], 32'h200);
        check("t4_pc0",  dl_pc[0],  32'h200);

        // Error response on PC 0x8.
        do_reset(1'b1, 1'b1, 1000);
        err_en   = 1'b1;
        err_addr = 32'h8;
        tick(10);
        check("t5_pc1",    dl_pc[1],    32'h4);
        check("t5_fault1", dl_fault[1], 32'd0);
        check("t5_pc2",    dl_pc[2],    32'h8);
        check("t5_fault2", dl_fault[2], 32'd1);
        check("t5_instr2", dl_instr[2], 32'hC0DE_0008);
        check("t5_pc3",    dl_pc[3],    32'hC);
        check("t5_fault3", dl_fault[3], 32'd0);

        // Redirect coinciding with a response and a pop.
        do_reset(1'b1, 1'b1, 1000);
        tick(3);
        i_redirect_valid = 1'b1;
        i_redirect_addr  = 32'h300;
        at_neg();
        check("t6_valid_at_redir", {31'd0, o_if_valid}, 32'd1);
        check("t6_pc_at_redir",    o_if_pc,             32'h0);
        tick(1);
        i_redirect_valid = 1'b0;
        i_if_ready       = 1'b0;
        at_neg();
        check("t6_flushed", {31'd0, o_if_valid}, 32'd0);
        check("t6_araddr",  o_im_araddr,         32'h300);
        tick(12);
        at_neg();
        check("t6_ar_count", 32'(ar_log.size()),    32'd7);
        check("t6_ar3",      ar_log[3],             32'h300);
        check("t6_ar6",      ar_log[6],             32'h30C);
        check("t6_arvalid",  {31'd0, o_im_arvalid}, 32'd0);
        check("t6_head_pc",  o_if_pc,               32'h300);
        check("t6_no_deliv", 32'(dl_pc.size()),     32'd0);
        tick(1);
        i_if_ready = 1'b1;
        tick(1);
        i_if_ready = 1'b0;
        tick(6);
        check("t6_deliv_count", 32'(dl_pc.size()),  32'd1);
        check("t6_deliv_pc",    dl_pc[0],           32'h300);
        check("t6_ar_count2",   32'(ar_log.size()), 32'd8);
        check("t6_ar7",         ar_log[7],          32'h310);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
